// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, branch-history counter states and the
// saturating counter update used by the branch resolver.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic [1:0] {
        BHT_SNT = 2'b00,
        BHT_WNT = 2'b01,
        BHT_WT  = 2'b10,
        BHT_ST  = 2'b11
    } BhtState;

    typedef enum logic {
        BR_INIT  = 1'b0,
        BR_READY = 1'b1
    } BrState;

    function automatic BhtState next_bht(input BhtState cur, input BranchOutcome outcome);
        BhtState nxt;
        nxt = cur;
        case (cur)
            BHT_SNT: nxt = (outcome == TAKEN) ? BHT_WNT : BHT_SNT;
            BHT_WNT: nxt = (outcome == TAKEN) ? BHT_WT  : BHT_SNT;
            BHT_WT:  nxt = (outcome == TAKEN) ? BHT_ST  : BHT_WNT;
            BHT_ST:  nxt = (outcome == TAKEN) ? BHT_ST  : BHT_WT;
            default: nxt = BHT_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolver_bht_table.sv
// Branch history table: combinational lookup port and one synchronous write
// port that either loads a value or applies the saturating update in place.
module bht_table
    import mips_core_pkg::*;
#(
    parameter int INDEX_BITS = 7
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output BhtState               rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_load,
    input  BhtState               wr_data,
    input  BranchOutcome          wr_outcome
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    BhtState mem_q [ENTRIES];
    BhtState wr_value_d;

    // Reads see the stored value, so a same-cycle write is only visible next cycle.
    assign rd_data = mem_q[rd_idx];

    // Select between an initialisation load and a trained counter value.
    always_comb begin
        wr_value_d = wr_data;
        if (wr_load) begin
            wr_value_d = wr_data;
        end else begin
            wr_value_d = next_bht(mem_q[wr_idx], wr_outcome);
        end
    end

    // Table storage; contents are rewritten by the owner rather than reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_value_d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: detects mispredicts, issues a registered
// redirect, trains the branch history table and counts branches/mispredicts.
module branch_resolver
    import mips_core_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          INDEX_BITS = 7,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    output logic                  pred_taken,
    input  logic                  res_valid,
    input  logic [ADDR_WIDTH-1:0] res_pc,
    input  BranchOutcome          res_outcome,
    input  BranchOutcome          res_predicted,
    input  logic [ADDR_WIDTH-1:0] res_target,
    input  logic [ADDR_WIDTH-1:0] res_fallthrough,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  init_busy,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = {INDEX_BITS{1'b1}};
    localparam logic [INDEX_BITS-1:0] IDX_ONE  = {{(INDEX_BITS-1){1'b0}}, 1'b1};

    BrState                  state_q, state_d;
    logic [INDEX_BITS-1:0]   init_idx_q, init_idx_d;
    logic                    redirect_valid_q, redirect_valid_d;
    logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
    logic [31:0]             branch_count_q, branch_count_d;
    logic [31:0]             mispredict_count_q, mispredict_count_d;

    logic [INDEX_BITS-1:0]   pred_idx_s, res_idx_s, wr_idx_s;
    logic                    wr_en_s, wr_load_s, mispredict_s;
    BhtState                 rd_data_s;

    assign pred_idx_s   = pred_pc[INDEX_BITS+1:2];
    assign res_idx_s    = res_pc[INDEX_BITS+1:2];
    assign mispredict_s = res_valid && (res_outcome != res_predicted);

    // FSM next state, table write control, redirect and statistics.
    always_comb begin
        state_d            = state_q;
        init_idx_d         = init_idx_q;
        wr_en_s            = 1'b0;
        wr_idx_s           = res_idx_s;
        wr_load_s          = 1'b0;
        case (state_q)
            BR_INIT: begin
                wr_en_s    = 1'b1;
                wr_idx_s   = init_idx_q;
                wr_load_s  = 1'b1;
                init_idx_d = init_idx_q + IDX_ONE;
                if (init_idx_q == LAST_IDX) begin
                    state_d = BR_READY;
                end else begin
                    state_d = BR_INIT;
                end
            end
            BR_READY: begin
                wr_en_s   = res_valid;
                wr_idx_s  = res_idx_s;
                wr_load_s = 1'b0;
                state_d   = BR_READY;
            end
            default: begin
                state_d    = BR_INIT;
                init_idx_d = {INDEX_BITS{1'b0}};
            end
        endcase

        // Redirects do not depend on the predictor, so they run during INIT too.
        redirect_valid_d = mispredict_s;
        if (mispredict_s) begin
            redirect_pc_d = (res_outcome == TAKEN) ? res_target : res_fallthrough;
        end else begin
            redirect_pc_d = redirect_pc_q;
        end

        branch_count_d     = branch_count_q + (res_valid ? 32'd1 : 32'd0);
        mispredict_count_d = mispredict_count_q + (mispredict_s ? 32'd1 : 32'd0);
    end

    // State, redirect and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q            <= BR_INIT;
            init_idx_q         <= {INDEX_BITS{1'b0}};
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= {ADDR_WIDTH{1'b0}};
            branch_count_q     <= 32'd0;
            mispredict_count_q <= 32'd0;
        end else begin
            state_q            <= state_d;
            init_idx_q         <= init_idx_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    bht_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_bht (
        .clk        (clk),
        .rd_idx     (pred_idx_s),
        .rd_data    (rd_data_s),
        .wr_en      (wr_en_s && rst_n),
        .wr_idx     (wr_idx_s),
        .wr_load    (wr_load_s),
        .wr_data    (BhtState'(INIT_STATE)),
        .wr_outcome (res_outcome)
    );

    assign pred_taken       = (state_q == BR_READY) && rd_data_s[1];
    assign init_busy        = (state_q == BR_INIT);
    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule
